// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and counter type for the scan timing block and the draw blocks.
package vga_pkg;
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FRONT = 10;

  localparam int VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_VIS + VGA_H_FRONT;
  localparam int VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_VIS + VGA_V_FRONT;

  localparam cnt_t VGA_H_VIS_START = cnt_t'(VGA_H_SYNC + VGA_H_BACK);
  localparam cnt_t VGA_H_VIS_END   = cnt_t'(VGA_H_SYNC + VGA_H_BACK + VGA_H_VIS - 1);
  localparam cnt_t VGA_V_VIS_START = cnt_t'(VGA_V_SYNC + VGA_V_BACK);
  localparam cnt_t VGA_V_VIS_END   = cnt_t'(VGA_V_SYNC + VGA_V_BACK + VGA_V_VIS - 1);

  function automatic logic in_span(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return (c >= lo) && (c <= hi);
  endfunction
endpackage

// File: rtl/vga_scan_timing_if.sv
// Counter/colour bus between the scan timing block (master) and the draw logic (slave).
interface vga_scan_timing_if;
  import vga_pkg::*;

  cnt_t HCounter;
  cnt_t VCounter;
  logic PixelEn;
  logic Visible;
  logic FrameStart;
  logic dR;
  logic dG;
  logic dB;

  modport master (output HCounter, VCounter, PixelEn, Visible, FrameStart,
                  input  dR, dG, dB);
  modport slave  (input  HCounter, VCounter, PixelEn, Visible, FrameStart,
                  output dR, dG, dB);
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping counter 0..TOTAL-1 advanced by en; wrap is high on the enabled cycle leaving TOTAL-1.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = VGA_H_TOTAL
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output cnt_t count,
  output logic wrap
);
  localparam cnt_t LAST = cnt_t'(TOTAL - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/vga_scan_timing.sv
// Raster scan generator: prescaled pixel tick, H/V counters, and registered syncs/colour to the DAC pins.
module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int H_VIS    = VGA_H_VIS,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int V_VIS    = VGA_V_VIS,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  vga_scan_timing_if.master   bus,
  output logic                HSync,
  output logic                VSync,
  output logic                R,
  output logic                G,
  output logic                B
);
  localparam int   H_TOTAL  = H_SYNC + H_BACK + H_VIS + H_FRONT;
  localparam int   V_TOTAL  = V_SYNC + V_BACK + V_VIS + V_FRONT;
  localparam cnt_t H_LO     = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t H_HI     = cnt_t'(H_SYNC + H_BACK + H_VIS - 1);
  localparam cnt_t V_LO     = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_HI     = cnt_t'(V_SYNC + V_BACK + V_VIS - 1);
  localparam cnt_t H_SYNC_C = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_C = cnt_t'(V_SYNC);

  logic pix_tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;
  logic v_wrap;
  logic visible;

  // Tick is gated by reset so nothing downstream advances while reset is held.
  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int            PW   = $clog2(CLK_DIV);
      localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
      logic [PW-1:0] presc;

      always_ff @(posedge clk) begin
        if (reset || presc == LAST) begin
          presc <= '0;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      assign pix_tick = !reset && (presc == LAST);
    end else begin : g_nodiv
      assign pix_tick = !reset;
    end
  endgenerate

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_tick),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign visible        = in_span(h_cnt, H_LO, H_HI) && in_span(v_cnt, V_LO, V_HI);
  assign bus.HCounter   = h_cnt;
  assign bus.VCounter   = v_cnt;
  assign bus.PixelEn    = pix_tick;
  assign bus.Visible    = visible;
  assign bus.FrameStart = v_wrap;

  // Pins reflect the pre-advance counter position, one pixel tick late.
  always_ff @(posedge clk) begin
    if (reset) begin
      HSync     <= ~SYNC_POL;
      VSync     <= ~SYNC_POL;
      {R, G, B} <= 3'b000;
    end else if (pix_tick) begin
      HSync     <= (h_cnt < H_SYNC_C) ? SYNC_POL : ~SYNC_POL;
      VSync     <= (v_cnt < V_SYNC_C) ? SYNC_POL : ~SYNC_POL;
      {R, G, B} <= visible ? {bus.dR, bus.dG, bus.dB} : 3'b000;
    end
  end
endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: default-geometry instance for line-level timing, plus two small-geometry instances for whole frames.
module tb_vga_scan_timing;
  localparam int SH = 4,  SV = 2;
  localparam int HT = 16, VT = 10;
  localparam int HLO = 6, HHI = 13, VLO = 4, VHI = 7;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic d_all = 1'b1, g_mode = 1'b0;
  logic hs_a, vs_a, r_a, g_a, b_a;
  logic hs_b, vs_b, r_b, g_b, b_b;
  logic hs_c, vs_c, r_c, g_c, b_c;

  int n_assert = 0, n_fail = 0;
  int err_cnt, err_pe, err_vis, err_fs, err_out;
  int n_pe, n_fs, n_r, n_g, n_hs_act, n_vs_act;
  int   div_s [2] = '{2, 1};
  logic pol_s [2] = '{1'b0, 1'b1};
  int   presc_m [2], h_m [2], v_m [2];
  logic hs_m [2], vs_m [2];
  logic [2:0] rgb_m [2];

  always #5 clk = ~clk;

  vga_scan_timing_if bus_a ();
  vga_scan_timing_if bus_b ();
  vga_scan_timing_if bus_c ();

  assign bus_a.dR = 1'b1;
  assign bus_a.dG = 1'b1;
  assign bus_a.dB = 1'b1;
  assign bus_b.dR = d_all;
  assign bus_b.dG = g_mode ? (bus_b.HCounter == 10'd9) : d_all;
  assign bus_b.dB = d_all;
  assign bus_c.dR = d_all;
  assign bus_c.dG = g_mode ? (bus_c.HCounter == 10'd9) : d_all;
  assign bus_c.dB = d_all;

  vga_scan_timing dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .HSync(hs_a), .VSync(vs_a), .R(r_a), .G(g_a), .B(b_a)
  );

  vga_scan_timing #(
    .CLK_DIV(2), .H_SYNC(4), .H_BACK(2), .H_VIS(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VIS(4), .V_FRONT(2), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .HSync(hs_b), .VSync(vs_b), .R(r_b), .G(g_b), .B(b_b)
  );

  vga_scan_timing #(
    .CLK_DIV(1), .H_SYNC(4), .H_BACK(2), .H_VIS(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VIS(4), .V_FRONT(2), .SYNC_POL(1'b1)
  ) dut_c (
    .clk(clk), .reset(rst_c), .bus(bus_c),
    .HSync(hs_c), .VSync(vs_c), .R(r_c), .G(g_c), .B(b_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int s, output logic pe, output logic vis, output logic fs,
                        output logic hs, output logic vs, output logic [2:0] rgb,
                        output int h, output int v);
    if (s == 0) begin
      pe = bus_b.PixelEn; vis = bus_b.Visible; fs = bus_b.FrameStart;
      hs = hs_b; vs = vs_b; rgb = {r_b, g_b, b_b};
      h = int'(bus_b.HCounter); v = int'(bus_b.VCounter);
    end else begin
      pe = bus_c.PixelEn; vis = bus_c.Visible; fs = bus_c.FrameStart;
      hs = hs_c; vs = vs_c; rgb = {r_c, g_c, b_c};
      h = int'(bus_c.HCounter); v = int'(bus_c.VCounter);
    end
  endtask

  task automatic model_reset(input int s);
    presc_m[s] = 0; h_m[s] = 0; v_m[s] = 0;
    hs_m[s] = ~pol_s[s]; vs_m[s] = ~pol_s[s]; rgb_m[s] = 3'b000;
  endtask

  task automatic clear_tallies();
    err_cnt = 0; err_pe = 0; err_vis = 0; err_fs = 0; err_out = 0;
    n_pe = 0; n_fs = 0; n_r = 0; n_g = 0; n_hs_act = 0; n_vs_act = 0;
  endtask

  // Independent raster model: expected counters, strobes and pin values per clock.
  task automatic run(input int s, input int nclk);
    logic pe_o, vis_o, fs_o, hs_o, vs_o, pe_m, vis_m, fs_m, dg_m;
    logic [2:0] rgb_o;
    int ho, vo;
    for (int i = 0; i < nclk; i++) begin
      sample(s, pe_o, vis_o, fs_o, hs_o, vs_o, rgb_o, ho, vo);
      pe_m  = (presc_m[s] == div_s[s] - 1);
      vis_m = (h_m[s] >= HLO) && (h_m[s] <= HHI) && (v_m[s] >= VLO) && (v_m[s] <= VHI);
      fs_m  = pe_m && (h_m[s] == HT - 1) && (v_m[s] == VT - 1);
      if (ho != h_m[s] || vo != v_m[s]) err_cnt++;
      if (pe_o !== pe_m) err_pe++;
      if (vis_o !== vis_m) err_vis++;
      if (fs_o !== fs_m) err_fs++;
      if (hs_o !== hs_m[s] || vs_o !== vs_m[s] || rgb_o !== rgb_m[s]) err_out++;
      tick();
      if (pe_m) begin
        hs_m[s]  = (h_m[s] < SH) ? pol_s[s] : ~pol_s[s];
        vs_m[s]  = (v_m[s] < SV) ? pol_s[s] : ~pol_s[s];
        dg_m     = g_mode ? (h_m[s] == 9) : d_all;
        rgb_m[s] = vis_m ? {d_all, dg_m, d_all} : 3'b000;
        if (h_m[s] == HT - 1) begin
          h_m[s] = 0;
          v_m[s] = (v_m[s] == VT - 1) ? 0 : v_m[s] + 1;
        end else begin
          h_m[s] = h_m[s] + 1;
        end
        presc_m[s] = 0;
        sample(s, pe_o, vis_o, fs_o, hs_o, vs_o, rgb_o, ho, vo);
        n_pe++;
        if (fs_m) n_fs++;
        if (rgb_o[2]) n_r++;
        if (rgb_o[1]) n_g++;
        if (hs_o === pol_s[s]) n_hs_act++;
        if (vs_o === pol_s[s]) n_vs_act++;
      end else begin
        presc_m[s] = presc_m[s] + 1;
      end
    end
  endtask

  task automatic chk_errs(input string pfx);
    chk({pfx, "_cnt_err"}, err_cnt, 0);
    chk({pfx, "_pe_err"},  err_pe,  0);
    chk({pfx, "_vis_err"}, err_vis, 0);
    chk({pfx, "_fs_err"},  err_fs,  0);
    chk({pfx, "_out_err"}, err_out, 0);
  endtask

  initial begin
    int npe, nhs, nvs, nrgb, nfs;
    logic pe;
    bit reached;

    // Default geometry: reset state and the first two lines.
    tick(); tick();
    chk("a_rst_h",   bus_a.HCounter, 0);
    chk("a_rst_v",   bus_a.VCounter, 0);
    chk("a_rst_hs",  hs_a, 1);
    chk("a_rst_vs",  vs_a, 1);
    chk("a_rst_rgb", {r_a, g_a, b_a}, 0);
    chk("a_rst_pe",  bus_a.PixelEn, 0);
    chk("a_rst_fs",  bus_a.FrameStart, 0);

    rst_a = 1'b0;
    #1;
    chk("a_pe_first_clk", bus_a.PixelEn, 0);
    npe = 0; nhs = 0; nvs = 0; nrgb = 0; nfs = 0;
    for (int i = 0; i < 3200; i++) begin
      if (i == 1) chk("a_pe_second_clk", bus_a.PixelEn, 1);
      if (i == 288) begin
        chk("a_h_after_288clk", bus_a.HCounter, 144);
        chk("a_vis_line0", bus_a.Visible, 0);
      end
      pe = bus_a.PixelEn;
      if (bus_a.FrameStart) nfs++;
      tick();
      if (pe) begin
        npe++;
        if (!hs_a) nhs++;
        if (!vs_a) nvs++;
        if ({r_a, g_a, b_a} != 3'b000) nrgb++;
      end
    end
    chk("a_ticks_2lines", npe, 1600);
    chk("a_h_wrapped", bus_a.HCounter, 0);
    chk("a_v_line2", bus_a.VCounter, 2);
    chk("a_hsync_low", nhs, 192);
    chk("a_vsync_low", nvs, 1600);
    chk("a_rgb_nonzero", nrgb, 0);
    chk("a_fs_none", nfs, 0);
    tick(); tick();
    chk("a_hs_line2_start", hs_a, 0);
    chk("a_vs_line2_end", vs_a, 1);
    rst_a = 1'b1;

    // Small geometry, CLK_DIV=2, active-low syncs: two frames with all colours on.
    rst_b = 1'b0;
    #1;
    model_reset(0);
    clear_tallies();
    run(0, 640);
    chk_errs("b2f");
    chk("b2f_ticks", n_pe, 320);
    chk("b2f_fs", n_fs, 2);
    chk("b2f_r_ones", n_r, 64);
    chk("b2f_hs_act", n_hs_act, 80);
    chk("b2f_vs_act", n_vs_act, 64);

    // Green from a single column only.
    g_mode = 1'b1; d_all = 1'b0;
    clear_tallies();
    run(0, 320);
    chk_errs("bg");
    chk("bg_g_ones", n_g, 4);
    chk("bg_r_ones", n_r, 0);
    g_mode = 1'b0; d_all = 1'b1;

    // Reset in the middle of the visible window.
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      if (h_m[0] == 10 && v_m[0] == 5) reached = 1'b1;
      else run(0, 1);
    end
    chk("b_reach_mid", reached, 1);
    chk("b_mid_h", bus_b.HCounter, 10);
    chk("b_mid_v", bus_b.VCounter, 5);
    chk("b_mid_vis", bus_b.Visible, 1);
    chk("b_mid_rgb", {r_b, g_b, b_b}, 3'b111);
    rst_b = 1'b1;
    #1;
    chk("b_rst_pe", bus_b.PixelEn, 0);
    chk("b_rst_fs", bus_b.FrameStart, 0);
    tick();
    rst_b = 1'b0;
    #1;
    chk("b_post_h", bus_b.HCounter, 0);
    chk("b_post_v", bus_b.VCounter, 0);
    chk("b_post_hs", hs_b, 1);
    chk("b_post_vs", vs_b, 1);
    chk("b_post_rgb", {r_b, g_b, b_b}, 0);
    chk("b_post_pe", bus_b.PixelEn, 0);
    model_reset(0);
    clear_tallies();
    run(0, 320);
    chk_errs("br");
    chk("br_fs", n_fs, 1);
    chk("br_r_ones", n_r, 32);
    rst_b = 1'b1;

    // Small geometry, CLK_DIV=1, active-high syncs.
    chk("c_rst_hs", hs_c, 0);
    chk("c_rst_vs", vs_c, 0);
    chk("c_rst_pe", bus_c.PixelEn, 0);
    rst_c = 1'b0;
    #1;
    model_reset(1);
    clear_tallies();
    run(1, 320);
    chk_errs("c");
    chk("c_ticks", n_pe, 320);
    chk("c_fs", n_fs, 2);
    chk("c_r_ones", n_r, 64);
    chk("c_hs_act", n_hs_act, 80);
    chk("c_vs_act", n_vs_act, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
